// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for an N-bit decoder: steps addr through 0..2**N-1, holds each
// address enabled for DWELL cycles, with optional BLANK cycles of dec_en low between steps.
module decoder_scan_ctrl #(
  parameter int N     = 4,
  parameter int DWELL = 10,
  parameter int BLANK = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  output logic [N-1:0] addr,
  output logic         dec_en,
  output logic         busy,
  output logic         step,
  output logic         frame,
  output logic         done
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [N-1:0]  ADDR_LAST  = {N{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [N-1:0]  addr_r, addr_s;
  logic          en_r, en_s;
  logic          busy_r, busy_s;
  logic          step_r, step_s;
  logic          frame_r, frame_s;
  logic          done_r, done_s;
  logic          mode_r, mode_s;
  logic [DW-1:0] dwell_r, dwell_s;
  logic [BW-1:0] blank_r, blank_s;

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
      step_r  <= 1'b0;
      frame_r <= 1'b0;
      done_r  <= 1'b0;
      mode_r  <= 1'b0;
      dwell_r <= '0;
      blank_r <= '0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      en_r    <= en_s;
      busy_r  <= busy_s;
      step_r  <= step_s;
      frame_r <= frame_s;
      done_r  <= done_s;
      mode_r  <= mode_s;
      dwell_r <= dwell_s;
      blank_r <= blank_s;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    en_s    = en_r;
    busy_s  = busy_r;
    step_s  = 1'b0;
    frame_s = 1'b0;
    done_s  = 1'b0;
    mode_s  = mode_r;
    dwell_s = dwell_r;
    blank_s = blank_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          state_s = ST_SCAN;
          addr_s  = '0;
          en_s    = 1'b1;
          busy_s  = 1'b1;
          mode_s  = mode;
          dwell_s = '0;
          blank_s = '0;
        end else begin
          addr_s  = '0;
          en_s    = 1'b0;
          busy_s  = 1'b0;
        end
      end
      ST_SCAN: begin
        if (stop) begin
          state_s = ST_IDLE;
          addr_s  = '0;
          en_s    = 1'b0;
          busy_s  = 1'b0;
          dwell_s = '0;
          blank_s = '0;
        end else if (dwell_r == DWELL_LAST) begin
          dwell_s = '0;
          if ((addr_r == ADDR_LAST) && !mode_r) begin
            // End of a single pass: no trailing blank.
            state_s = ST_IDLE;
            addr_s  = '0;
            en_s    = 1'b0;
            busy_s  = 1'b0;
            frame_s = 1'b1;
            done_s  = 1'b1;
          end else begin
            // Advance; the last address wraps to 0 through the natural overflow.
            addr_s  = addr_r + N'(1);
            step_s  = 1'b1;
            frame_s = (addr_r == ADDR_LAST);
            if (BLANK == 0) begin
              state_s = ST_SCAN;
              en_s    = 1'b1;
            end else begin
              state_s = ST_BLANK;
              en_s    = 1'b0;
              blank_s = '0;
            end
          end
        end else begin
          dwell_s = dwell_r + DW'(1);
        end
      end
      ST_BLANK: begin
        if (stop) begin
          state_s = ST_IDLE;
          addr_s  = '0;
          en_s    = 1'b0;
          busy_s  = 1'b0;
          dwell_s = '0;
          blank_s = '0;
        end else if (blank_r == BLANK_LAST) begin
          state_s = ST_SCAN;
          en_s    = 1'b1;
          dwell_s = '0;
          blank_s = '0;
        end else begin
          blank_s = blank_r + BW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        addr_s  = '0;
        en_s    = 1'b0;
        busy_s  = 1'b0;
        mode_s  = 1'b0;
        dwell_s = '0;
        blank_s = '0;
      end
    endcase
  end

  assign addr   = addr_r;
  assign dec_en = en_r;
  assign busy   = busy_r;
  assign step   = step_r;
  assign frame  = frame_r;
  assign done   = done_r;

endmodule
